// File: rtl/vec_sca_bridge.sv
// Scalar-to-vector bridge: request FIFO toward the vector decoder, per-ID
// completion buffer, and in-order or completion-order return to the core.
module vec_sca_bridge #(
  parameter int INSTR_BITS    = 32,
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 3,
  parameter int REQ_DEPTH     = 4,
  parameter int IN_ORDER      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [INSTR_BITS-1:0]    req_instr_i,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] req_id_i,
  output logic                     dec_valid_o,
  input  logic                     dec_ready_i,
  output logic [INSTR_BITS-1:0]    dec_instr_o,
  output logic [XLEN-1:0]          dec_rs1_o,
  output logic [XLEN-1:0]          dec_rs2_o,
  output logic [TRANS_ID_BITS-1:0] dec_id_o,
  input  logic                     be_resp_valid_i,
  input  logic                     be_resp_err_i,
  input  logic [XLEN-1:0]          be_resp_res_i,
  input  logic [TRANS_ID_BITS-1:0] be_resp_id_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     resp_err_o,
  output logic [XLEN-1:0]          resp_res_o,
  output logic [TRANS_ID_BITS-1:0] resp_id_o,
  output logic [TRANS_ID_BITS:0]   outstanding_o,
  output logic                     unexp_resp_o
);

  localparam int NID = 1 << TRANS_ID_BITS;
  localparam int RPW = $clog2(REQ_DEPTH);
  localparam int OW  = TRANS_ID_BITS + 1;

  localparam logic [RPW:0]           RQ_FULL  = (RPW+1)'(REQ_DEPTH);
  localparam logic [RPW:0]           RQ_ONE   = (RPW+1)'(1);
  localparam logic [RPW-1:0]         RP_ONE   = RPW'(1);
  localparam logic [OW-1:0]          ID_LIMIT = OW'(NID);
  localparam logic [OW-1:0]          OUT_ONE  = OW'(1);
  localparam logic [TRANS_ID_BITS-1:0] OP_ONE = TRANS_ID_BITS'(1);
  localparam logic [NID-1:0]         ID_ONE   = NID'(1);

  // Lowest-numbered ID whose completion is waiting in the buffer.
  function automatic logic [TRANS_ID_BITS-1:0] lowest_done(input logic [NID-1:0] d);
    logic [TRANS_ID_BITS-1:0] r;
    r = {TRANS_ID_BITS{1'b0}};
    for (int i = NID - 1; i >= 0; i--) begin
      if (d[i]) begin
        r = TRANS_ID_BITS'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Request FIFO storage
  logic [INSTR_BITS-1:0]    rq_instr_r [REQ_DEPTH];
  logic [XLEN-1:0]          rq_rs1_r   [REQ_DEPTH];
  logic [XLEN-1:0]          rq_rs2_r   [REQ_DEPTH];
  logic [TRANS_ID_BITS-1:0] rq_id_r    [REQ_DEPTH];
  logic [RPW-1:0]           rq_wp_r;
  logic [RPW-1:0]           rq_rp_r;
  logic [RPW:0]             rq_cnt_r;

  // Order FIFO: acceptance order of IDs, one slot per trackable ID
  logic [TRANS_ID_BITS-1:0] ord_id_r [NID];
  logic [TRANS_ID_BITS-1:0] ord_wp_r;
  logic [TRANS_ID_BITS-1:0] ord_rp_r;
  logic [OW-1:0]            outstanding_r;

  // Per-ID tracking and response buffer
  logic [NID-1:0]           busy_r;
  logic [NID-1:0]           done_r;
  logic [NID-1:0]           buf_err_r;
  logic [XLEN-1:0]          buf_res_r [NID];

  logic                     held_r;
  logic [TRANS_ID_BITS-1:0] held_id_r;
  logic                     unexp_r;

  logic                     rq_full_s;
  logic                     rq_empty_s;
  logic                     accept_s;
  logic                     dec_fire_s;
  logic                     be_ok_s;
  logic                     be_drop_s;
  logic                     sel_valid_s;
  logic [TRANS_ID_BITS-1:0] sel_id_s;
  logic                     retire_s;
  logic [NID-1:0]           acc_mask_s;
  logic [NID-1:0]           ret_mask_s;
  logic [NID-1:0]           be_mask_s;

  assign rq_full_s   = (rq_cnt_r == RQ_FULL);
  assign rq_empty_s  = (rq_cnt_r == {(RPW+1){1'b0}});

  // A full FIFO blocks acceptance even if the decoder pops this cycle.
  assign req_ready_o = !rq_full_s && !busy_r[req_id_i] && (outstanding_r < ID_LIMIT);
  assign accept_s    = req_valid_i && req_ready_o;
  assign dec_fire_s  = !rq_empty_s && dec_ready_i;

  assign be_ok_s     = be_resp_valid_i && busy_r[be_resp_id_i] && !done_r[be_resp_id_i];
  assign be_drop_s   = be_resp_valid_i && !be_ok_s;

  // Response selection: order-FIFO head, or lowest done ID held while stalled
  always_comb begin
    sel_id_s    = {TRANS_ID_BITS{1'b0}};
    sel_valid_s = 1'b0;
    if (IN_ORDER != 0) begin
      sel_id_s    = ord_id_r[ord_rp_r];
      sel_valid_s = done_r[ord_id_r[ord_rp_r]];
    end else begin
      sel_id_s    = held_r ? held_id_r : lowest_done(done_r);
      sel_valid_s = |done_r;
    end
  end

  assign retire_s   = sel_valid_s && resp_ready_i;
  assign acc_mask_s = accept_s ? (ID_ONE << req_id_i)     : {NID{1'b0}};
  assign ret_mask_s = retire_s ? (ID_ONE << sel_id_s)     : {NID{1'b0}};
  assign be_mask_s  = be_ok_s  ? (ID_ONE << be_resp_id_i) : {NID{1'b0}};

  // Request FIFO push/pop and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REQ_DEPTH; i++) begin
        rq_instr_r[i] <= {INSTR_BITS{1'b0}};
        rq_rs1_r[i]   <= {XLEN{1'b0}};
        rq_rs2_r[i]   <= {XLEN{1'b0}};
        rq_id_r[i]    <= {TRANS_ID_BITS{1'b0}};
      end
      rq_wp_r  <= {RPW{1'b0}};
      rq_rp_r  <= {RPW{1'b0}};
      rq_cnt_r <= {(RPW+1){1'b0}};
    end else begin
      if (accept_s) begin
        rq_instr_r[rq_wp_r] <= req_instr_i;
        rq_rs1_r[rq_wp_r]   <= req_rs1_i;
        rq_rs2_r[rq_wp_r]   <= req_rs2_i;
        rq_id_r[rq_wp_r]    <= req_id_i;
        rq_wp_r             <= rq_wp_r + RP_ONE;
      end
      if (dec_fire_s) begin
        rq_rp_r <= rq_rp_r + RP_ONE;
      end
      case ({accept_s, dec_fire_s})
        2'b10:   rq_cnt_r <= rq_cnt_r + RQ_ONE;
        2'b01:   rq_cnt_r <= rq_cnt_r - RQ_ONE;
        default: rq_cnt_r <= rq_cnt_r;
      endcase
    end
  end

  // Order FIFO and outstanding count; in completion order only occupancy matters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NID; i++) begin
        ord_id_r[i] <= {TRANS_ID_BITS{1'b0}};
      end
      ord_wp_r      <= {TRANS_ID_BITS{1'b0}};
      ord_rp_r      <= {TRANS_ID_BITS{1'b0}};
      outstanding_r <= {OW{1'b0}};
    end else begin
      if (accept_s) begin
        ord_id_r[ord_wp_r] <= req_id_i;
        ord_wp_r           <= ord_wp_r + OP_ONE;
      end
      if (retire_s) begin
        ord_rp_r <= ord_rp_r + OP_ONE;
      end
      case ({accept_s, retire_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_ONE;
        2'b01:   outstanding_r <= outstanding_r - OUT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Busy/done flags and response buffer writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r    <= {NID{1'b0}};
      done_r    <= {NID{1'b0}};
      buf_err_r <= {NID{1'b0}};
      for (int i = 0; i < NID; i++) begin
        buf_res_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      busy_r <= (busy_r & ~ret_mask_s) | acc_mask_s;
      done_r <= (done_r & ~ret_mask_s) | be_mask_s;
      if (be_ok_s) begin
        buf_err_r[be_resp_id_i] <= be_resp_err_i;
        buf_res_r[be_resp_id_i] <= be_resp_res_i;
      end
    end
  end

  // Freeze the completion-order choice while the core stalls it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_r    <= 1'b0;
      held_id_r <= {TRANS_ID_BITS{1'b0}};
    end else if (retire_s) begin
      held_r    <= 1'b0;
    end else if (sel_valid_s) begin
      held_r    <= 1'b1;
      held_id_r <= sel_id_s;
    end
  end

  // Dropped back-end response pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unexp_r <= 1'b0;
    end else begin
      unexp_r <= be_drop_s;
    end
  end

  assign dec_valid_o   = !rq_empty_s;
  assign dec_instr_o   = rq_instr_r[rq_rp_r];
  assign dec_rs1_o     = rq_rs1_r[rq_rp_r];
  assign dec_rs2_o     = rq_rs2_r[rq_rp_r];
  assign dec_id_o      = rq_id_r[rq_rp_r];

  assign resp_valid_o  = sel_valid_s;
  assign resp_id_o     = sel_id_s;
  assign resp_err_o    = buf_err_r[sel_id_s];
  assign resp_res_o    = buf_res_r[sel_id_s];

  assign outstanding_o = outstanding_r;
  assign unexp_resp_o  = unexp_r;

endmodule

// File: tb/tb_vec_sca_bridge.sv
// Bench for vec_sca_bridge: one in-order and one completion-order instance
// sharing stimulus, each compared against its own queue-level model.
module tb_vec_sca_bridge;

  logic        clk;
  logic        rst_ni;
  logic        req_valid;
  logic [31:0] req_instr, req_rs1, req_rs2;
  logic [2:0]  req_id;
  logic        dec_ready;
  logic        be_valid, be_err;
  logic [31:0] be_res;
  logic [2:0]  be_id;
  logic        resp_ready;

  logic        req_ready   [2];
  logic        dec_valid   [2];
  logic [31:0] dec_instr   [2];
  logic [31:0] dec_rs1     [2];
  logic [31:0] dec_rs2     [2];
  logic [2:0]  dec_id      [2];
  logic        resp_valid  [2];
  logic        resp_err    [2];
  logic [31:0] resp_res    [2];
  logic [2:0]  resp_id     [2];
  logic [3:0]  outstanding [2];
  logic        unexp       [2];

  int total = 0;
  int bad   = 0;

  vec_sca_bridge #(.IN_ORDER(1)) dut_io (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready[0]), .req_instr_i(req_instr),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_id_i(req_id),
    .dec_valid_o(dec_valid[0]), .dec_ready_i(dec_ready), .dec_instr_o(dec_instr[0]),
    .dec_rs1_o(dec_rs1[0]), .dec_rs2_o(dec_rs2[0]), .dec_id_o(dec_id[0]),
    .be_resp_valid_i(be_valid), .be_resp_err_i(be_err), .be_resp_res_i(be_res),
    .be_resp_id_i(be_id),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready), .resp_err_o(resp_err[0]),
    .resp_res_o(resp_res[0]), .resp_id_o(resp_id[0]),
    .outstanding_o(outstanding[0]), .unexp_resp_o(unexp[0])
  );

  vec_sca_bridge #(.IN_ORDER(0)) dut_ooo (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready[1]), .req_instr_i(req_instr),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_id_i(req_id),
    .dec_valid_o(dec_valid[1]), .dec_ready_i(dec_ready), .dec_instr_o(dec_instr[1]),
    .dec_rs1_o(dec_rs1[1]), .dec_rs2_o(dec_rs2[1]), .dec_id_o(dec_id[1]),
    .be_resp_valid_i(be_valid), .be_resp_err_i(be_err), .be_resp_res_i(be_res),
    .be_resp_id_i(be_id),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready), .resp_err_o(resp_err[1]),
    .resp_res_o(resp_res[1]), .resp_id_o(resp_id[1]),
    .outstanding_o(outstanding[1]), .unexp_resp_o(unexp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = in-order instance, 1 = completion-order
  int          rq_n     [2];
  logic [31:0] rq_instr [2][4];
  logic [31:0] rq_rs1   [2][4];
  logic [31:0] rq_rs2   [2][4];
  logic [2:0]  rq_id    [2][4];
  logic        busy_m   [2][8];
  logic        done_m   [2][8];
  logic        err_m    [2][8];
  logic [31:0] res_m    [2][8];
  logic [2:0]  ord_m    [2][8];
  int          ord_n    [2];
  logic        held_m   [2];
  logic [2:0]  held_id_m[2];
  logic        unexp_m  [2];

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rq_n[d] = 0; ord_n[d] = 0; held_m[d] = 1'b0; held_id_m[d] = 3'd0; unexp_m[d] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        busy_m[d][i] = 1'b0; done_m[d][i] = 1'b0; err_m[d][i] = 1'b0; res_m[d][i] = 32'd0;
      end
    end
  endtask

  function automatic logic exp_ready(input int d);
    return (rq_n[d] < 4) && !busy_m[d][req_id] && (ord_n[d] < 8);
  endfunction

  // Which response the core should see: oldest accepted, or lowest done (sticky while stalled)
  task automatic exp_resp(input int d, output logic v, output logic [2:0] id);
    v = 1'b0; id = 3'd0;
    if (d == 0) begin
      if (ord_n[0] > 0) begin
        id = ord_m[0][0];
        v  = done_m[0][id];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (done_m[1][i]) begin v = 1'b1; id = 3'(i); end
      end
      if (held_m[1]) id = held_id_m[1];
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      logic v;
      logic [2:0] rid;
      chk("req_ready", d, req_ready[d], exp_ready(d));
      chk("dec_valid", d, dec_valid[d], rq_n[d] > 0);
      if (rq_n[d] > 0) begin
        chk("dec_id", d, dec_id[d], rq_id[d][0]);
        chk("dec_instr", d, dec_instr[d], rq_instr[d][0]);
        chk("dec_rs1", d, dec_rs1[d], rq_rs1[d][0]);
        chk("dec_rs2", d, dec_rs2[d], rq_rs2[d][0]);
      end
      chk("outstanding", d, outstanding[d], ord_n[d]);
      chk("unexp", d, unexp[d], unexp_m[d]);
      exp_resp(d, v, rid);
      chk("resp_valid", d, resp_valid[d], v);
      if (v) begin
        chk("resp_id", d, resp_id[d], rid);
        chk("resp_res", d, resp_res[d], res_m[d][rid]);
        chk("resp_err", d, resp_err[d], err_m[d][rid]);
      end
    end
  endtask

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      logic acc, fire, v, ret, ok;
      logic [2:0] rid;
      int p;
      acc  = req_valid && exp_ready(d);
      fire = (rq_n[d] > 0) && dec_ready;
      exp_resp(d, v, rid);
      ret  = v && resp_ready;
      ok   = be_valid && busy_m[d][be_id] && !done_m[d][be_id];
      if (fire) begin
        for (int k = 0; k < 3; k++) begin
          rq_instr[d][k] = rq_instr[d][k+1]; rq_rs1[d][k] = rq_rs1[d][k+1];
          rq_rs2[d][k] = rq_rs2[d][k+1]; rq_id[d][k] = rq_id[d][k+1];
        end
        rq_n[d]--;
      end
      if (acc) begin
        rq_instr[d][rq_n[d]] = req_instr; rq_rs1[d][rq_n[d]] = req_rs1;
        rq_rs2[d][rq_n[d]] = req_rs2; rq_id[d][rq_n[d]] = req_id;
        rq_n[d]++;
      end
      if (ok) begin
        done_m[d][be_id] = 1'b1; err_m[d][be_id] = be_err; res_m[d][be_id] = be_res;
      end
      unexp_m[d] = be_valid && !ok;
      if (ret) begin
        busy_m[d][rid] = 1'b0; done_m[d][rid] = 1'b0; held_m[d] = 1'b0;
        p = -1;
        for (int i = 0; i < ord_n[d]; i++) if (ord_m[d][i] == rid) p = i;
        if (p >= 0) begin
          for (int i = p; i < ord_n[d] - 1; i++) ord_m[d][i] = ord_m[d][i+1];
          ord_n[d]--;
        end
      end else if (v) begin
        held_m[d] = 1'b1; held_id_m[d] = rid;
      end
      if (acc) begin
        busy_m[d][req_id] = 1'b1;
        ord_m[d][ord_n[d]] = req_id;
        ord_n[d]++;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_model();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; req_id = 3'd0; req_instr = 32'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    dec_ready = 1'b0; be_valid = 1'b0; be_err = 1'b0; be_res = 32'd0; be_id = 3'd0;
    resp_ready = 1'b0;
  endtask

  task automatic send(input logic [2:0] id);
    req_valid = 1'b1; req_id = id;
    req_instr = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  typedef struct packed {
    logic       vld;
    logic [2:0] id;
    logic       drdy;
    logic       e_rdy;
    logic       e_dv;
    logic [2:0] e_did;
    logic [3:0] e_out;
  } vec_t;

  vec_t        tbl [6];
  logic [2:0]  seen_id  [2][8];
  logic [31:0] seen_res [2][8];
  int          seen_n   [2];
  logic [2:0]  eid  [2][3];
  logic [31:0] eres [2][3];

  initial begin
    tbl[0] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0};
    tbl[1] = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 3'd0, 4'd1};
    tbl[2] = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 3'd1, 4'd2};
    tbl[3] = '{1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 3'd2, 4'd3};
    tbl[4] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 4'd4};
    tbl[5] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd4};
    eid[0][0] = 3'd0; eid[0][1] = 3'd1; eid[0][2] = 3'd2;
    eres[0][0] = 32'h00; eres[0][1] = 32'h11; eres[0][2] = 32'h22;
    eid[1][0] = 3'd2; eid[1][1] = 3'd0; eid[1][2] = 3'd1;
    eres[1][0] = 32'h22; eres[1][1] = 32'h00; eres[1][2] = 32'h11;

    // Reset values
    idle();
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_dec_valid", d, dec_valid[d], 1'b0);
      chk("rst_resp_valid", d, resp_valid[d], 1'b0);
      chk("rst_outstanding", d, outstanding[d], 4'd0);
      chk("rst_unexp", d, unexp[d], 1'b0);
      chk("rst_dec_instr", d, dec_instr[d], 32'd0);
      chk("rst_resp_res", d, resp_res[d], 32'd0);
    end
    @(negedge clk);
    rst_ni = 1'b1;

    // Four back-to-back requests, decoder always ready
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].vld) send(tbl[r].id);
      else begin req_valid = 1'b0; req_id = tbl[r].id; end
      dec_ready = tbl[r].drdy;
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("tbl_req_ready", d, req_ready[d], tbl[r].e_rdy);
        chk("tbl_dec_valid", d, dec_valid[d], tbl[r].e_dv);
        if (tbl[r].e_dv) chk("tbl_dec_id", d, dec_id[d], tbl[r].e_did);
        chk("tbl_outstanding", d, outstanding[d], tbl[r].e_out);
      end
      cycle();
    end

    // Out-of-order completions 2,0,1
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin send(3'(i)); cycle(); end
    req_valid = 1'b0;
    be_valid = 1'b1; be_id = 3'd2; be_res = 32'h22; cycle();
    be_id = 3'd0; be_res = 32'h00;
    #1;
    chk("io_wait_head", 0, resp_valid[0], 1'b0);
    chk("ooo_first_sel", 1, resp_id[1], 3'd2);
    cycle();
    be_id = 3'd1; be_res = 32'h11;
    #1;
    chk("ooo_hold_sel", 1, resp_id[1], 3'd2);
    cycle();
    be_valid = 1'b0; resp_ready = 1'b1;
    seen_n[0] = 0; seen_n[1] = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        if (resp_valid[d] && seen_n[d] < 8) begin
          seen_id[d][seen_n[d]] = resp_id[d]; seen_res[d][seen_n[d]] = resp_res[d];
          seen_n[d]++;
        end
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      chk("ret_count", d, seen_n[d], 3);
      for (int k = 0; k < 3 && k < seen_n[d]; k++) begin
        chk("ret_order_id", d, seen_id[d][k], eid[d][k]);
        chk("ret_order_res", d, seen_res[d][k], eres[d][k]);
      end
    end

    // Full request FIFO with the decoder stalled
    do_reset();
    for (int i = 0; i < 4; i++) begin send(3'(i)); cycle(); end
    send(3'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_stall", 0, req_ready[0], 1'b0);
      cycle();
    end
    dec_ready = 1'b1;
    #1;
    chk("full_pop_same_cycle", 0, req_ready[0], 1'b0);
    cycle();
    dec_ready = 1'b0;
    #1;
    chk("after_pop_ready", 0, req_ready[0], 1'b1);
    cycle();
    req_valid = 1'b0;
    #1;
    chk("fifth_accepted", 0, outstanding[0], 4'd5);
    chk("head_after_pop", 0, dec_id[0], 3'd1);
    cycle();

    // Busy-ID stall and dropped response
    do_reset();
    dec_ready = 1'b1;
    send(3'd5); cycle();
    be_valid = 1'b1; be_id = 3'd5; be_res = 32'h55;
    #1;
    for (int d = 0; d < 2; d++) chk("busy_stall", d, req_ready[d], 1'b0);
    cycle();
    be_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("busy_done_stall", d, req_ready[d], 1'b0);
    cycle();
    resp_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("busy_retire_cycle", d, req_ready[d], 1'b0);
    cycle();
    resp_ready = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("busy_released", d, req_ready[d], 1'b1);
    cycle();
    req_valid = 1'b0; be_valid = 1'b1; be_id = 3'd6; be_res = 32'h66;
    cycle();
    be_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("unexp_pulse", d, unexp[d], 1'b1);
      chk("unexp_no_resp", d, resp_valid[d], 1'b0);
    end
    cycle();
    #1;
    for (int d = 0; d < 2; d++) chk("unexp_single", d, unexp[d], 1'b0);
    cycle();

    // Reset with work in flight
    do_reset();
    for (int i = 0; i < 3; i++) begin send(3'(i)); cycle(); end
    req_valid = 1'b0; dec_ready = 1'b1; be_valid = 1'b1; be_id = 3'd0; be_res = 32'hAB;
    cycle();
    dec_ready = 1'b0; be_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("pre_rst_outstanding", d, outstanding[d], 4'd3);
      chk("pre_rst_resp_valid", d, resp_valid[d], 1'b1);
    end
    rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_dec_valid", d, dec_valid[d], 1'b0);
      chk("async_rst_resp_valid", d, resp_valid[d], 1'b0);
      chk("async_rst_outstanding", d, outstanding[d], 4'd0);
      chk("async_rst_dec_id", d, dec_id[d], 3'd0);
      chk("async_rst_resp_res", d, resp_res[d], 32'd0);
      chk("async_rst_req_ready", d, req_ready[d], 1'b1);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    send(3'd0); cycle();
    req_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_accept", d, outstanding[d], 4'd1);
      chk("post_rst_dec_id", d, dec_id[d], 3'd0);
    end
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_id     = 3'($urandom_range(0, 7));
      req_instr  = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
      dec_ready  = ($urandom_range(0, 9) < 7);
      be_valid   = 1'($urandom_range(0, 1));
      be_id      = 3'($urandom_range(0, 7));
      be_err     = 1'($urandom_range(0, 1));
      be_res     = $urandom;
      resp_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
